seven_segment_reader: RTL

- Receive-side counterpart of the accumulator's two-digit seven-segment output.
- Takes the two 7-bit segment patterns, decodes them back to an 8-bit value, and filters out transient patterns with a stability counter.
- Checks that successive committed values follow the accumulator's +1 (mod 256) sequence.
- Serves as an on-chip/bench monitor: reports decoded value, illegal patterns, sequence breaks and a saturating error count.

---
 rtl/seven_segment_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_reader.sv
// Seven-segment monitor: decodes two digit patterns back to a byte, debounces with a
// stability counter, checks the +1 sequence and counts illegal/sequence errors.
module seven_segment_reader #(
  parameter int unsigned STABLE_CNT = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_en,
  input  logic [6:0] Sin1,
  input  logic [6:0] Sin0,
  output logic [7:0] Dout,
  output logic       valid,
  output logic       illegal,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_LOCKED
  } state_e;

  // Returns {legal, nibble} for one active-high {g..a} pattern.
  function automatic logic [4:0] seg_decode(input logic [SEG_W-1:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                have_prev_q, have_prev_d;
  logic                valid_q, valid_d;
  logic                illegal_q, illegal_d;
  logic                seq_err_q, seq_err_d;
  logic [DATA_W-1:0]   err_cnt_q, err_cnt_d;

  logic [SEG_W-1:0]    seg1, seg0;
  logic [4:0]          dec1, dec0;
  logic                legal;
  logic [DATA_W-1:0]   value;
  logic                counted;

  always_comb begin
    seg1  = ACTIVE_LOW ? ~Sin1 : Sin1;
    seg0  = ACTIVE_LOW ? ~Sin0 : Sin0;
    dec1  = seg_decode(seg1);
    dec0  = seg_decode(seg0);
    legal = dec1[4] & dec0[4];
    value = {dec1[3:0], dec0[3:0]};
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    have_prev_d = have_prev_q;
    valid_d     = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    counted     = 1'b0;

    if (s_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (legal) begin
            cand_d  = value;
            cnt_d   = CNT_W'(1);
            state_d = S_TRACK;
            counted = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end
        S_TRACK: begin
          if (!legal) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            illegal_d = 1'b1;
          end else if (value == cand_q) begin
            cnt_d   = cnt_q + CNT_W'(1);
            counted = 1'b1;
          end else begin
            cand_d  = value;
            cnt_d   = CNT_W'(1);
            counted = 1'b1;
          end
        end
        S_LOCKED: begin
          if (!legal) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            illegal_d = 1'b1;
          end else if (value != dout_q) begin
            state_d = S_TRACK;
            cand_d  = value;
            cnt_d   = CNT_W'(1);
            counted = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Commit when the candidate's sample count reaches the threshold.
    if (counted && (cnt_d == CNT_W'(STABLE_CNT))) begin
      dout_d      = value;
      valid_d     = 1'b1;
      state_d     = S_LOCKED;
      have_prev_d = 1'b1;
      seq_err_d   = have_prev_q && (value != (dout_q + DATA_W'(1)));
    end

    if ((illegal_d || seq_err_d) && (err_cnt_q != {DATA_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      have_prev_q <= have_prev_d;
      valid_q     <= valid_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign Dout    = dout_q;
  assign valid   = valid_q;
  assign illegal = illegal_q;
  assign seq_err = seq_err_q;
  assign locked  = (state_q == S_LOCKED);
  assign err_cnt = err_cnt_q;

endmodule
